epc_master: RTL and testbench
=============================

Name: epc_master

Overview:
- EPC bus initiator: takes single-word read/write requests on a valid/ready request port and runs them as EPC transactions against the register-block responder (addr, be, cs_n, rnw, write data, rdy, read data).
- Returns read data and status on a one-cycle response strobe.
- Used for fabric-side register access and as the bus driver in register-block loopback/regression.
- A timeout guards against a responder that never asserts rdy.

Parameters:
TIMEOUT, 255, max cycles in WAIT without epc_rdy before abort (1..65535)
ERR_W, 8, width of saturating timeout-error counter

Ports:
clk  in  1  system clock (all logic on rising edge)
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at rising edge
req_rnw  in  1  1=read, 0=write
req_addr  in  32  byte address
req_be  in  4  byte enables, bit i = data[8i+7:8i]
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  read data (0 for writes/timeouts)
rsp_err  out  1  1 = transaction timed out
busy  out  1  transaction in progress
err_cnt  out  ERR_W  saturating count of timeouts
epc_cs_n  out  1  chip select, active-low
epc_rnw  out  1  read/not-write
epc_addr  out  32  address to responder
epc_be  out  4  byte enables to responder
epc_burst  out  1  tied 0 (single-beat only)
epc_wdata  out  32  write data to responder (responder's data_i)
epc_rdata  in  32  read data from responder (responder's data_o)
epc_rdy  in  1  responder ready/complete

Behaviour:
- All outputs registered. Reset values: req_ready=0 while rst high, 1 in first cycle after release; epc_cs_n=1; everything else 0.
- Reset asserted mid-transaction: cs_n returns to 1 immediately (async); no response is issued; counter cleared.
- FSM: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, busy=0.
  - On accept at edge T, latch rnw/addr/be/wdata into epc_* outputs, go WAIT.
  - epc_cs_n=0 from T+1.
  - For reads, epc_wdata holds its previous value (don't-care to the responder).
- WAIT:
  - epc_cs_n=0, busy=1, req_ready=0. epc_* outputs stable for the whole transaction.
  - Timeout counter (16-bit) cleared on entry, incremented each WAIT cycle.
  - epc_rdy=1 at an edge: capture rsp_rdata = rnw ? epc_rdata : 0; rsp_err=0; go RESP.
  - Otherwise, when counter == TIMEOUT-1: rsp_rdata=0, rsp_err=1; err_cnt+1, saturating at all-ones; go RESP.
  - epc_rdy and timeout on the same edge: rdy wins, no error.
  - Minimum latency: rdy in first cs_n-low cycle gives rsp_valid at T+2.
- RESP:
  - Exactly one cycle. rsp_valid=1, epc_cs_n=1, busy=0, req_ready=1.
  - A request may be accepted in this cycle. That guarantees at least one cs_n-high cycle between back-to-back transactions.
  - rsp_rdata/rsp_err hold until the next response.
- epc_rdy while cs_n=1 is ignored.
- epc_burst is constant 0.
- req_* are not sampled outside an accept edge.

Test Plan:
- Write addr=0x0000_0010, be=0xF, wdata=0xDEAD_BEEF, responder rdy after 3 cycles -> cs_n low 3 cycles with addr/be/wdata stable, rnw=0; rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
- Read addr=0x24, responder returns 0x1234_5678 with rdy in first cs_n-low cycle -> rsp_valid at T+2, rsp_rdata=0x1234_5678.
- Back-to-back: req_valid held high with 4 requests, rdy immediate -> each cs_n-low phase is separated by exactly one cs_n-high cycle; 4 rsp_valid pulses in request order.
- Timeout: TIMEOUT=8, responder never rdy -> cs_n low 8 cycles, rsp_err=1, rsp_rdata=0, err_cnt 0->1. Repeat with ERR_W=2 for 5 timeouts -> err_cnt saturates at 3.
- Rdy arriving on the timeout-terminal cycle (cycle 8 with TIMEOUT=8) -> rsp_err=0, data captured, err_cnt unchanged.
- Assert rst in WAIT cycle 2 -> cs_n high asynchronously, no rsp_valid. After release, a new read completes normally and err_cnt=0.

Source files
------------

// File: rtl/epc_master.sv
// epc_master: single-beat EPC bus initiator with a request/response front end,
// a per-transaction rdy timeout and a saturating timeout-error counter.
module epc_master #(
    parameter int TIMEOUT = 255,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rnw,
    input  logic [31:0]      req_addr,
    input  logic [3:0]       req_be,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt,
    output logic             epc_cs_n,
    output logic             epc_rnw,
    output logic [31:0]      epc_addr,
    output logic [3:0]       epc_be,
    output logic             epc_burst,
    output logic [31:0]      epc_wdata,
    input  logic [31:0]      epc_rdata,
    input  logic             epc_rdy
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             rnw_q, rnw_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             accept;
    // Ready is a decode of the state register, masked while reset is held
    // so it reads 0 in reset and 1 in the first cycle after release.
    assign req_ready = ~rst & (state_q != ST_WAIT);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = state_q == ST_RESP;
    assign busy      = state_q == ST_WAIT;
    assign epc_cs_n  = state_q != ST_WAIT;
    assign epc_rnw   = rnw_q;
    assign epc_addr  = addr_q;
    assign epc_be    = be_q;
    assign epc_wdata = wdata_q;
    assign epc_burst = 1'b0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign err_cnt   = err_cnt_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // rdy takes priority over a timeout on the same edge
                if (epc_rdy) begin
                    rdata_d = rnw_q ? epc_rdata : 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d   = 32'd0;
                    err_d     = 1'b1;
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
                    state_d   = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = 16'd0;
                    rnw_d   = req_rnw;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_rnw ? wdata_q : req_wdata;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_epc_master.sv
// tb_epc_master: directed bench for epc_master with TIMEOUT=8, ERR_W=2;
// the bench plays the responder and checks bus timing and responses.
module tb_epc_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rnw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  err_cnt;
    logic        epc_cs_n;
    logic        epc_rnw;
    logic [31:0] epc_addr;
    logic [3:0]  epc_be;
    logic        epc_burst;
    logic [31:0] epc_wdata;
    logic [31:0] epc_rdata;
    logic        epc_rdy;
    logic        auto_rdy = 1'b0;
    logic        rdy_drv = 1'b0;
    logic [31:0] rd_drv = '0;
    logic [31:0] last_wd = '0;
    int          checks = 0;
    int          errors = 0;

    // auto mode answers every cycle with cs_n low using address-derived data
    assign epc_rdy   = auto_rdy ? ~epc_cs_n : rdy_drv;
    assign epc_rdata = auto_rdy ? (epc_addr ^ 32'hA5A5_0000) : rd_drv;

    always #5 clk = ~clk;

    epc_master #(.TIMEOUT(8), .ERR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .err_cnt(err_cnt),
        .epc_cs_n(epc_cs_n), .epc_rnw(epc_rnw), .epc_addr(epc_addr),
        .epc_be(epc_be), .epc_burst(epc_burst), .epc_wdata(epc_wdata),
        .epc_rdata(epc_rdata), .epc_rdy(epc_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction, called at a falling edge. delay = cs_n-low cycle on
    // which rdy is given (0 = never); exp_low = expected cs_n-low length.
    task automatic txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int delay, input logic [31:0] rd,
                       input int exp_low, input logic exp_err);
        int n;
        logic [31:0] exp_rd;
        exp_rd = (rnw && !exp_err) ? rd : 32'd0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_be    = 4'h0;
        req_wdata = 32'h0BAD_0BAD;
        req_rnw   = ~rnw;
        n = 0;
        while (epc_cs_n == 1'b0 && n < 100) begin
            n++;
            chk("epc_addr", epc_addr, addr);
            chk("epc_be", 32'(epc_be), 32'(be));
            chk("epc_rnw", 32'(epc_rnw), 32'(rnw));
            chk("epc_wdata", epc_wdata, rnw ? last_wd : wdata);
            chk("busy_wait", 32'(busy), 32'd1);
            chk("req_ready_wait", 32'(req_ready), 32'd0);
            chk("rsp_valid_wait", 32'(rsp_valid), 32'd0);
            rd_drv  = rd;
            rdy_drv = (n == delay);
            @(negedge clk);
            rdy_drv = 1'b0;
        end
        if (!rnw) last_wd = wdata;
        chk("cs_low_cycles", 32'(n), 32'(exp_low));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("busy_resp", 32'(busy), 32'd0);
        chk("req_ready_resp", 32'(req_ready), 32'd1);
        chk("burst", 32'(epc_burst), 32'd0);
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("rsp_rdata_hold", rsp_rdata, exp_rd);
        chk("cs_n_idle", 32'(epc_cs_n), 32'd1);
    endtask

    initial begin
        int idx, nrsp, nlow, gap;
        logic acc, prev_cs;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cs_n", 32'(epc_cs_n), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_burst", 32'(epc_burst), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge clk);

        txn(1'b0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 3, 32'h0, 3, 1'b0);
        txn(1'b1, 32'h0000_0024, 4'hF, 32'h0, 1, 32'h1234_5678, 1, 1'b0);

        // back-to-back reads with req_valid held high and immediate rdy
        auto_rdy = 1'b1;
        idx = 0; nrsp = 0; nlow = 0; gap = 0; prev_cs = 1'b1;
        req_rnw = 1'b1; req_be = 4'hF; req_addr = 32'h100; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            acc = req_valid && req_ready;
            if (epc_cs_n == 1'b0 && prev_cs == 1'b1) begin
                if (nlow > 0) chk("b2b_gap", 32'(gap), 32'd1);
                nlow++;
                gap = 0;
            end
            if (epc_cs_n == 1'b1 && nlow > 0) gap++;
            if (rsp_valid) begin
                chk("b2b_rdata", rsp_rdata, (32'h100 + 32'(4 * nrsp)) ^ 32'hA5A5_0000);
                nrsp++;
            end
            prev_cs = epc_cs_n;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 4) req_addr = 32'h100 + 32'(4 * idx);
                else req_valid = 1'b0;
            end
        end
        chk("b2b_rsp_count", 32'(nrsp), 32'd4);
        chk("b2b_low_phases", 32'(nlow), 32'd4);
        auto_rdy = 1'b0;

        chk("err_cnt_pre_to", 32'(err_cnt), 32'd0);
        txn(1'b1, 32'h0000_0030, 4'hF, 32'h0, 0, 32'h7777_7777, 8, 1'b1);
        chk("err_cnt_first_to", 32'(err_cnt), 32'd1);
        txn(1'b1, 32'h0000_0034, 4'h3, 32'h0, 8, 32'hCAFE_F00D, 8, 1'b0);
        chk("err_cnt_rdy_terminal", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 4; i++)
            txn(1'b0, 32'h40 + 32'(4 * i), 4'h5, 32'h1111_0000 + 32'(i), 0, 32'h0, 8, 1'b1);
        chk("err_cnt_saturate", 32'(err_cnt), 32'd3);

        // reset in the second WAIT cycle
        req_rnw = 1'b1; req_addr = 32'h60; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_cs_low", 32'(epc_cs_n), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", 32'(epc_cs_n), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        last_wd = 32'h0;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        txn(1'b1, 32'h0000_0050, 4'hF, 32'h0, 2, 32'h0000_55AA, 2, 1'b0);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
